// File: rtl/move_ranker.sv
// rtl/move_ranker.sv - sequential legal-move ranker streaming moves in descending score order
module move_ranker #(
    parameter int NUM_CELLS = 9,
    parameter int SCORE_W   = 7,
    parameter int IDX_W     = 4,
    parameter int MAX_RANKS = 9,
    parameter int RANK_W    = 4
) (
    input  logic                         Clk,
    input  logic                         reset,
    input  logic                         start_i,
    input  logic                         abort_i,
    input  logic [NUM_CELLS*SCORE_W-1:0] scores_i,
    input  logic [NUM_CELLS-1:0]         occ_i,
    output logic                         busy_o,
    output logic                         move_valid_o,
    input  logic                         move_ready_i,
    output logic [IDX_W-1:0]             move_idx_o,
    output logic [SCORE_W-1:0]           move_score_o,
    output logic [RANK_W-1:0]            move_rank_o,
    output logic                         done_o,
    output logic                         no_move_o
);

    typedef enum logic [1:0] {IDLE, SCAN, OUT, DONE} state_t;

    state_t                     state_q, state_d;
    logic signed [SCORE_W-1:0]  score_q [NUM_CELLS];
    logic signed [SCORE_W-1:0]  score_d [NUM_CELLS];
    logic [NUM_CELLS-1:0]       occ_q, occ_d;
    logic [NUM_CELLS-1:0]       tried_q, tried_d;
    logic [RANK_W-1:0]          rank_q, rank_d;
    logic [IDX_W-1:0]           cnt_q, cnt_d;
    logic                       found_q, found_d;
    logic [IDX_W-1:0]           best_idx_q, best_idx_d;
    logic signed [SCORE_W-1:0]  best_score_q, best_score_d;
    logic [IDX_W-1:0]           move_idx_q, move_idx_d;
    logic [SCORE_W-1:0]         move_score_q, move_score_d;
    logic [RANK_W-1:0]          move_rank_q, move_rank_d;
    logic                       done_q, done_d;
    logic                       no_move_q, no_move_d;

    logic signed [SCORE_W-1:0]  cur_score;
    logic                       eligible;
    logic                       take;

    assign cur_score = score_q[cnt_q];
    assign eligible  = !occ_q[cnt_q] && !tried_q[cnt_q];
    // found flag instead of a sentinel so the most negative score still wins;
    // strict > keeps the lowest index on ties
    assign take      = eligible && (!found_q || (cur_score > best_score_q));

    always_comb begin
        state_d      = state_q;
        score_d      = score_q;
        occ_d        = occ_q;
        tried_d      = tried_q;
        rank_d       = rank_q;
        cnt_d        = cnt_q;
        found_d      = found_q;
        best_idx_d   = best_idx_q;
        best_score_d = best_score_q;
        move_idx_d   = move_idx_q;
        move_score_d = move_score_q;
        move_rank_d  = move_rank_q;
        done_d       = 1'b0;
        no_move_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    for (int k = 0; k < NUM_CELLS; k++) begin
                        score_d[k] = scores_i[k*SCORE_W +: SCORE_W];
                    end
                    occ_d   = occ_i;
                    tried_d = '0;
                    rank_d  = '0;
                    cnt_d   = '0;
                    found_d = 1'b0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else begin
                    if (take) begin
                        found_d      = 1'b1;
                        best_idx_d   = cnt_q;
                        best_score_d = cur_score;
                    end
                    if (cnt_q == IDX_W'(NUM_CELLS - 1)) begin
                        if (found_d) begin
                            // presented move is captured here so it stays put
                            // while the next scan reuses the best registers
                            state_d      = OUT;
                            move_idx_d   = best_idx_d;
                            move_score_d = best_score_d;
                            move_rank_d  = rank_q;
                        end else begin
                            state_d = DONE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            OUT: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (move_ready_i) begin
                    tried_d[best_idx_q] = 1'b1;
                    rank_d  = rank_q + 1'b1;
                    found_d = 1'b0;
                    cnt_d   = '0;
                    state_d = (rank_d == RANK_W'(MAX_RANKS)) ? DONE : SCAN;
                end
            end
            DONE: begin
                // done/no_move are registered: the pulse appears the cycle after DONE
                done_d    = 1'b1;
                no_move_d = (rank_q == '0);
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q <= IDLE;
            for (int k = 0; k < NUM_CELLS; k++) begin
                score_q[k] <= '0;
            end
            occ_q        <= '0;
            tried_q      <= '0;
            rank_q       <= '0;
            cnt_q        <= '0;
            found_q      <= 1'b0;
            best_idx_q   <= '0;
            best_score_q <= '0;
            move_idx_q   <= '0;
            move_score_q <= '0;
            move_rank_q  <= '0;
            done_q       <= 1'b0;
            no_move_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            score_q      <= score_d;
            occ_q        <= occ_d;
            tried_q      <= tried_d;
            rank_q       <= rank_d;
            cnt_q        <= cnt_d;
            found_q      <= found_d;
            best_idx_q   <= best_idx_d;
            best_score_q <= best_score_d;
            move_idx_q   <= move_idx_d;
            move_score_q <= move_score_d;
            move_rank_q  <= move_rank_d;
            done_q       <= done_d;
            no_move_q    <= no_move_d;
        end
    end

    assign busy_o       = (state_q != IDLE);
    assign move_valid_o = (state_q == OUT);
    assign move_idx_o   = move_idx_q;
    assign move_score_o = move_score_q;
    assign move_rank_o  = move_rank_q;
    assign done_o       = done_q;
    assign no_move_o    = no_move_q;

endmodule

// File: tb/tb_move_ranker.sv
// tb/tb_move_ranker.sv - self-checking bench for move_ranker
module tb_move_ranker;
    localparam int N  = 9;
    localparam int SW = 7;
    localparam int IW = 4;
    localparam int RW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, start_i, abort_i, move_ready_i;
    logic [N*SW-1:0] scores_i;
    logic [N-1:0]  occ_i;

    logic [1:0]         busy_w, valid_w, done_w, nomove_w;
    logic [1:0][IW-1:0] idx_w;
    logic [1:0][SW-1:0] score_w;
    logic [1:0][RW-1:0] rank_w;

    // instance 0: MAX_RANKS=9, instance 1: MAX_RANKS=3, shared stimulus
    move_ranker #(.NUM_CELLS(N), .SCORE_W(SW), .IDX_W(IW), .MAX_RANKS(9), .RANK_W(RW)) u_dut9 (
        .Clk(clk), .reset(reset), .start_i(start_i), .abort_i(abort_i),
        .scores_i(scores_i), .occ_i(occ_i), .busy_o(busy_w[0]), .move_valid_o(valid_w[0]),
        .move_ready_i(move_ready_i), .move_idx_o(idx_w[0]), .move_score_o(score_w[0]),
        .move_rank_o(rank_w[0]), .done_o(done_w[0]), .no_move_o(nomove_w[0]));

    move_ranker #(.NUM_CELLS(N), .SCORE_W(SW), .IDX_W(IW), .MAX_RANKS(3), .RANK_W(RW)) u_dut3 (
        .Clk(clk), .reset(reset), .start_i(start_i), .abort_i(abort_i),
        .scores_i(scores_i), .occ_i(occ_i), .busy_o(busy_w[1]), .move_valid_o(valid_w[1]),
        .move_ready_i(move_ready_i), .move_idx_o(idx_w[1]), .move_score_o(score_w[1]),
        .move_rank_o(rank_w[1]), .done_o(done_w[1]), .no_move_o(nomove_w[1]));

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: per job, the legal cells are ordered by (score desc, index asc)
    // using a counting sort; timing follows the latency rules.
    int m_max [2] = '{9, 3};
    bit m_busy [2], m_valid [2], m_end [2], m_done [2], m_nomove [2];
    int m_wait [2], m_k [2], m_len [2], m_idx [2], m_score [2], m_rank [2];
    int m_list [2][N];
    int m_sc [2][N];

    int obs9[$];
    int obs3[$];
    int done_cnt [2] = '{0, 0};

    always @(posedge clk) begin
        if (!reset && !abort_i && move_ready_i) begin
            if (valid_w[0]) obs9.push_back(int'(idx_w[0]));
            if (valid_w[1]) obs3.push_back(int'(idx_w[1]));
        end
        if (done_w[0]) done_cnt[0]++;
        if (done_w[1]) done_cnt[1]++;

        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                m_busy[d] = 0; m_valid[d] = 0; m_end[d] = 0; m_done[d] = 0; m_nomove[d] = 0;
                m_idx[d] = 0; m_score[d] = 0; m_rank[d] = 0; m_k[d] = 0; m_wait[d] = 0;
            end else begin
                m_done[d] = 0;
                m_nomove[d] = 0;
                if (m_busy[d]) begin
                    if (m_end[d]) begin
                        m_end[d] = 0; m_busy[d] = 0; m_done[d] = 1; m_nomove[d] = (m_k[d] == 0);
                    end else if (abort_i) begin
                        m_busy[d] = 0; m_valid[d] = 0;
                    end else if (m_valid[d]) begin
                        if (move_ready_i) begin
                            m_valid[d] = 0;
                            m_k[d]++;
                            if (m_k[d] == m_max[d]) m_end[d] = 1;
                            else m_wait[d] = N;
                        end
                    end else begin
                        m_wait[d]--;
                        if (m_wait[d] == 0) begin
                            if (m_k[d] < m_len[d]) begin
                                m_valid[d] = 1;
                                m_idx[d]   = m_list[d][m_k[d]];
                                m_score[d] = m_sc[d][m_idx[d]];
                                m_rank[d]  = m_k[d];
                            end else begin
                                m_end[d] = 1;
                            end
                        end
                    end
                end else if (start_i) begin
                    for (int c = 0; c < N; c++) m_sc[d][c] = int'($signed(scores_i[c*SW +: SW]));
                    m_len[d] = 0;
                    for (int c = 0; c < N; c++) begin
                        if (!occ_i[c]) begin
                            int pos;
                            pos = 0;
                            for (int j = 0; j < N; j++) begin
                                if (!occ_i[j] && (m_sc[d][j] > m_sc[d][c] || (m_sc[d][j] == m_sc[d][c] && j < c)))
                                    pos++;
                            end
                            m_list[d][pos] = c;
                            m_len[d]++;
                        end
                    end
                    m_busy[d] = 1; m_k[d] = 0; m_wait[d] = N;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("busy%0d", d),   int'(busy_w[d]),   int'(m_busy[d]));
                chk($sformatf("valid%0d", d),  int'(valid_w[d]),  int'(m_valid[d]));
                chk($sformatf("done%0d", d),   int'(done_w[d]),   int'(m_done[d]));
                chk($sformatf("nomove%0d", d), int'(nomove_w[d]), int'(m_nomove[d]));
                chk($sformatf("idx%0d", d),    int'(idx_w[d]),    m_idx[d]);
                chk($sformatf("score%0d", d),  int'($signed(score_w[d])), m_score[d]);
                chk($sformatf("rank%0d", d),   int'(rank_w[d]),   m_rank[d]);
            end
        end
    end

    int tbl [N] = '{0, 5, -3, 12, 7, 12, 1, -64, 2};
    int exp_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [N-1:0] occ, input logic rdy);
        occ_i = occ;
        move_ready_i = rdy;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!valid_w[0] && n < 60) begin tick(); n++; end
        chk({name, "_valid_timeout"}, int'(n < 60), 1);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy_w != 2'b00 && n < 400) begin tick(); n++; end
        chk({name, "_idle_timeout"}, int'(n < 400), 1);
        tick();
        tick();
    endtask

    task automatic check_obs(input string name, input int d);
        int n;
        n = (d == 0) ? obs9.size() : obs3.size();
        chk({name, "_len"}, n, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < n; i++)
            chk($sformatf("%s_%0d", name, i), (d == 0) ? obs9[i] : obs3[i], exp_q[i]);
    endtask

    task automatic clear_obs();
        obs9.delete();
        obs3.delete();
    endtask

    initial begin
        int n;
        int dc0;
        reset = 1'b1; start_i = 1'b0; abort_i = 1'b0; move_ready_i = 1'b0; occ_i = '0;
        for (int k = 0; k < N; k++) scores_i[k*SW +: SW] = SW'(tbl[k]);
        tick();
        chk_on = 1;
        tick();
        reset = 1'b0;
        tick();
        chk("reset_busy", int'(busy_w), 0);
        chk("reset_valid", int'(valid_w), 0);

        // T1: full ranking, ready held high
        clear_obs();
        start_job(9'h000, 1'b1);
        n = 0;
        while (!valid_w[1] && n < 40) begin tick(); n++; end
        chk("t1_first_valid_lat", n, N);
        wait_idle("t1");
        exp_q = '{3, 5, 4};
        check_obs("t1_max3", 1);
        exp_q = '{3, 5, 4, 1, 8, 6, 0, 2, 7};
        check_obs("t1_max9", 0);
        chk("t1_done9", done_cnt[0], 1);
        chk("t1_done3", done_cnt[1], 1);

        // T2: cells 3 and 5 occupied
        clear_obs();
        start_job(9'b000101000, 1'b1);
        wait_idle("t2");
        exp_q = '{4, 1, 8, 6, 0, 2, 7};
        check_obs("t2_max9", 0);
        exp_q = '{4, 1, 8};
        check_obs("t2_max3", 1);

        // T3: board full
        clear_obs();
        start_job(9'h1FF, 1'b1);
        n = 0;
        while (!done_w[0] && n < 40) begin tick(); n++; end
        chk("t3_done_lat", n, N + 1);
        chk("t3_no_move", int'(nomove_w[0]), 1);
        wait_idle("t3");
        chk("t3_moves", obs9.size() + obs3.size(), 0);

        // T4: backpressure
        clear_obs();
        start_job(9'h000, 1'b0);
        wait_valid("t4");
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("t4_hold_valid", int'(valid_w[0]), 1);
            chk("t4_hold_idx", int'(idx_w[0]), 3);
            chk("t4_hold_score", int'($signed(score_w[0])), 12);
        end
        move_ready_i = 1'b1;
        tick();
        move_ready_i = 1'b0;
        chk("t4_one_accept", obs9.size(), 1);
        chk("t4_valid_drop", int'(valid_w[0]), 0);
        move_ready_i = 1'b1;
        wait_idle("t4");

        // T5: abort in SCAN, then in OUT with ready high
        clear_obs();
        dc0 = done_cnt[0];
        start_job(9'h000, 1'b0);
        tick(); tick(); tick(); tick();
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk("t5_scan_abort_busy", int'(busy_w), 0);
        start_job(9'h000, 1'b0);
        wait_valid("t5");
        move_ready_i = 1'b1;
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        move_ready_i = 1'b0;
        chk("t5_out_abort_busy", int'(busy_w), 0);
        chk("t5_out_abort_accepts", obs9.size() + obs3.size(), 0);
        tick(); tick(); tick();
        chk("t5_no_done", done_cnt[0], dc0);
        start_job(9'h000, 1'b0);
        wait_valid("t5b");
        chk("t5_fresh_rank", int'(rank_w[0]), 0);
        chk("t5_fresh_idx", int'(idx_w[0]), 3);
        move_ready_i = 1'b1;
        wait_idle("t5");

        // T6: start while busy, then reset mid-OUT
        clear_obs();
        start_job(9'h000, 1'b0);
        wait_valid("t6");
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_busy", int'(busy_w), 0);
        chk("t6_valid", int'(valid_w), 0);
        chk("t6_idx", int'(idx_w[0]), 0);
        chk("t6_score", int'(score_w[0]), 0);
        chk("t6_rank", int'(rank_w[0]), 0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busy_w != 2'b00 || valid_w != 2'b00) n++;
        end
        chk("t6_no_second_job", n, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
